// File: rtl/fb_pkg.sv
// Framebuffer geometry shared by the write scheduler and the scanout address math.
package fb_pkg;

    localparam int FB_AW     = 18;
    localparam int FB_STRIDE = 800;
    localparam int FB_ROWS   = 240;
    localparam int FB_WORDS  = FB_STRIDE * FB_ROWS;

    typedef logic [FB_AW-1:0] fb_addr_t;

endpackage

// File: rtl/fb_write_scheduler_if.sv
// Capture stream and framebuffer write port as seen by the write scheduler.
interface fb_write_scheduler_if #(
    parameter int AW = fb_pkg::FB_AW
) ();

    logic          cap_valid;
    logic          cap_ready;
    logic [AW-1:0] cap_addr;
    logic          cap_data;

    logic          fb_we;
    logic [AW-1:0] fb_waddr;
    logic          fb_wdata;

    modport master (
        output cap_valid, cap_addr, cap_data,
        input  cap_ready, fb_we, fb_waddr, fb_wdata
    );

    modport slave (
        input  cap_valid, cap_addr, cap_data,
        output cap_ready, fb_we, fb_waddr, fb_wdata
    );

endinterface

// File: rtl/fb_cap_fifo.sv
// Small synchronous FIFO buffering capture pixels; no fall-through, so a push into an
// empty FIFO is visible on rdata only from the following cycle.
module fb_cap_fifo #(
    parameter  int W     = 19,
    parameter  int DEPTH = 4,
    localparam int IW    = $clog2(DEPTH),
    localparam int LW    = IW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [IW-1:0] wr_ptr;
    logic [IW-1:0] rd_ptr;
    logic          push_en;
    logic          pop_en;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; the pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port owner: arbitrates the buffered capture stream against the
// full-screen clear engine, with capture priority bounded by MAX_CAP_RUN.
module fb_write_scheduler #(
    parameter  int   AW          = fb_pkg::FB_AW,
    parameter  int   FB_WORDS    = fb_pkg::FB_WORDS,
    parameter  int   FIFO_DEPTH  = 4,
    parameter  int   MAX_CAP_RUN = 8,
    parameter  logic CLR_VALUE   = 1'b0,
    localparam int   LW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fb_write_scheduler_if.slave   bus,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic [LW-1:0]         cap_level
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int            RW        = $clog2(MAX_CAP_RUN + 1);
    localparam logic [RW-1:0] RUN_LIMIT = RW'(MAX_CAP_RUN);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FB_WORDS - 1);

    logic [1:0]    state;
    logic [AW-1:0] clr_ptr;
    logic [RW-1:0] run;
    logic          in_clear;
    logic          cap_sel;
    logic          clr_sel;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_rdata;

    fb_cap_fifo #(
        .W     (AW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_cap_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (bus.cap_valid),
        .wdata   ({bus.cap_addr, bus.cap_data}),
        .pop     (cap_sel),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (cap_level)
    );

    assign in_clear      = (state == ST_CLEAR);
    assign clr_busy      = in_clear;
    assign clr_done      = (state == ST_DONE);
    assign bus.cap_ready = !fifo_full;

    // Capture wins unless it has already taken MAX_CAP_RUN slots in a row during a clear.
    assign cap_sel = !fifo_empty && (!in_clear || (run < RUN_LIMIT));
    assign clr_sel = !cap_sel && in_clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            clr_ptr <= '0;
            run     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clr_sel) begin
                        if (clr_ptr == LAST_ADDR) begin
                            state   <= ST_DONE;
                            clr_ptr <= '0;
                        end else begin
                            clr_ptr <= clr_ptr + 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (fifo_empty || !in_clear) begin
                run <= '0;
            end else if (cap_sel) begin
                if (run != RUN_LIMIT) begin
                    run <= run + 1'b1;
                end
            end else begin
                run <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.fb_we    <= 1'b0;
            bus.fb_waddr <= '0;
            bus.fb_wdata <= 1'b0;
        end else begin
            bus.fb_we <= cap_sel || clr_sel;
            if (cap_sel) begin
                bus.fb_waddr <= fifo_rdata[AW:1];
                bus.fb_wdata <= fifo_rdata[0];
            end else if (clr_sel) begin
                bus.fb_waddr <= clr_ptr;
                bus.fb_wdata <= CLR_VALUE;
            end
        end
    end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler with a shortened framebuffer (100 words).
module tb_fb_write_scheduler;

    localparam int AW    = 18;
    localparam int WORDS = 100;
    localparam int DEPTH = 4;
    localparam int RUN   = 8;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b1;
    logic       clr_start = 1'b0;
    logic       clr_busy;
    logic       clr_done;
    logic [2:0] cap_level;

    fb_write_scheduler_if #(.AW(AW)) bus ();

    fb_write_scheduler #(
        .AW          (AW),
        .FB_WORDS    (WORDS),
        .FIFO_DEPTH  (DEPTH),
        .MAX_CAP_RUN (RUN),
        .CLR_VALUE   (1'b0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .cap_level (cap_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // scoreboard state for the mixed clear/capture run
    int q[$];
    int exp_clr;
    int n_clr;
    int run_len;
    int gap_bad;
    int clr_bad;
    int cap_bad;
    int cap_wr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic observe();
        if (bus.fb_we) begin
            if (bus.fb_wdata) begin
                if (q.size() == 0) cap_bad++;
                else if (32'(bus.fb_waddr) != q.pop_front()) cap_bad++;
                cap_wr++;
                run_len++;
            end else begin
                if (32'(bus.fb_waddr) != exp_clr) clr_bad++;
                if (n_clr > 0 && run_len != RUN) gap_bad++;
                exp_clr++;
                n_clr++;
                run_len = 0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr;
        int drops;
        int bad_addr;
        int bad_data;
        int busy_cyc;
        int done_cnt;
        int done_addr;
        int exp_a;
        int n;
        bit repulsed;
        bit seen_full;
        bit acc;

        bus.cap_valid = 1'b0;
        bus.cap_addr  = '0;
        bus.cap_data  = 1'b0;

        // reset values, asserted before any clock edge
        #2 reset_n = 1'b0;
        #1;
        check("rst_fb_we",     32'(bus.fb_we),     0);
        check("rst_fb_waddr",  32'(bus.fb_waddr),  0);
        check("rst_fb_wdata",  32'(bus.fb_wdata),  0);
        check("rst_clr_busy",  32'(clr_busy),      0);
        check("rst_clr_done",  32'(clr_done),      0);
        check("rst_cap_level", 32'(cap_level),     0);
        check("rst_cap_ready", 32'(bus.cap_ready), 1);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // 10 back-to-back pixels, first write one edge after acceptance
        wr = 0;
        drops = 0;
        for (int t = 1; t <= 14; t++) begin
            if (t <= 10) begin
                bus.cap_valid = 1'b1;
                bus.cap_addr  = AW'(100 + t - 1);
                bus.cap_data  = 1'((t - 1) & 1);
                if (!bus.cap_ready) drops++;
            end else begin
                bus.cap_valid = 1'b0;
            end
            tick();
            if (t == 1) check("stream_lat0", 32'(bus.fb_we), 0);
            if (t == 2) check("stream_lat1", 32'(bus.fb_we), 1);
            if (t == 5) check("stream_level", 32'(cap_level), 1);
            if (bus.fb_we) begin
                check("stream_addr", 32'(bus.fb_waddr), 32'(100 + t - 2));
                check("stream_data", 32'(bus.fb_wdata), 32'((t - 2) & 1));
                wr++;
            end
        end
        check("stream_writes", 32'(wr), 10);
        check("stream_ready_drops", 32'(drops), 0);
        check("stream_level_end", 32'(cap_level), 0);

        // clear alone, with an ignored second clr_start at clr_ptr=50
        wr = 0;
        bad_addr = 0;
        bad_data = 0;
        busy_cyc = 0;
        done_cnt = 0;
        done_addr = -1;
        exp_a = 0;
        repulsed = 1'b0;
        clr_start = 1'b1;
        for (int t = 0; t < WORDS + 30; t++) begin
            tick();
            clr_start = 1'b0;
            if (clr_busy) busy_cyc++;
            if (bus.fb_we) begin
                if (32'(bus.fb_waddr) != exp_a) bad_addr++;
                if (bus.fb_wdata != 1'b0) bad_data++;
                exp_a++;
                wr++;
                if (bus.fb_waddr == AW'(49) && !repulsed) begin
                    clr_start = 1'b1;
                    repulsed = 1'b1;
                end
            end
            if (clr_done) begin
                done_cnt++;
                done_addr = 32'(bus.fb_waddr);
            end
        end
        check("clr_writes",    32'(wr),        WORDS);
        check("clr_addr_order", 32'(bad_addr), 0);
        check("clr_data",      32'(bad_data),  0);
        check("clr_busy_cyc",  32'(busy_cyc),  WORDS);
        check("clr_done_cnt",  32'(done_cnt),  1);
        check("clr_done_last", 32'(done_addr), WORDS - 1);
        check("clr_idle_busy", 32'(clr_busy),  0);

        // clear with continuous capture: 8 capture slots then 1 clear slot
        q.delete();
        exp_clr = 0;
        n_clr = 0;
        run_len = 0;
        gap_bad = 0;
        clr_bad = 0;
        cap_bad = 0;
        cap_wr = 0;
        n = 0;
        seen_full = 1'b0;
        done_cnt = 0;
        for (int t = 0; t < 3000; t++) begin
            bus.cap_valid = 1'b1;
            bus.cap_addr  = AW'(1000 + n);
            bus.cap_data  = 1'b1;
            clr_start     = (t == 2);
            acc = bus.cap_ready;
            tick();
            if (acc) begin
                q.push_back(1000 + n);
                n++;
            end
            observe();
            if (!bus.cap_ready) seen_full = 1'b1;
            if (clr_done) begin
                done_cnt++;
                break;
            end
        end
        bus.cap_valid = 1'b0;
        clr_start = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            observe();
        end
        check("mix_done_cnt",  32'(done_cnt),  1);
        check("mix_clr_slots", 32'(n_clr),     WORDS);
        check("mix_clr_order", 32'(clr_bad),   0);
        check("mix_gap_bad",   32'(gap_bad),   0);
        check("mix_cap_order", 32'(cap_bad),   0);
        check("mix_cap_count", 32'(cap_wr),    32'(n));
        check("mix_leftover",  32'(q.size()),  0);
        check("mix_backpress", 32'(seen_full), 1);
        check("mix_level_end", 32'(cap_level), 0);

        // asynchronous reset mid-clear with 3 pixels buffered
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int t = 0; t < 200; t++) begin
            bus.cap_valid = 1'b1;
            bus.cap_addr  = AW'(5000 + t);
            bus.cap_data  = 1'b1;
            tick();
            if (cap_level == 3'd3) break;
        end
        bus.cap_valid = 1'b0;
        check("arst_pre_busy",  32'(clr_busy),  1);
        check("arst_pre_level", 32'(cap_level), 3);
        #2 reset_n = 1'b0;
        #1;
        check("arst_fb_we",     32'(bus.fb_we),     0);
        check("arst_fb_waddr",  32'(bus.fb_waddr),  0);
        check("arst_fb_wdata",  32'(bus.fb_wdata),  0);
        check("arst_clr_busy",  32'(clr_busy),      0);
        check("arst_clr_done",  32'(clr_done),      0);
        check("arst_cap_level", 32'(cap_level),     0);
        check("arst_cap_ready", 32'(bus.cap_ready), 1);
        tick();
        tick();
        #2 reset_n = 1'b1;
        wr = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (bus.fb_we) wr++;
        end
        check("post_writes", 32'(wr),        0);
        check("post_busy",   32'(clr_busy),  0);
        check("post_done",   32'(clr_done),  0);
        check("post_level",  32'(cap_level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
